apb_uart: RTL and testbench

- APB slave UART for the `uart` port of the AHB-to-APB bridge (decode window 0xF1xx_xxxx).
- Provides 8N1 serial TX through a small TX FIFO and serial RX into a single holding register.
- Has a programmable baud divisor, sticky error flags and a level interrupt to the interrupt controller.
- Zero-wait-state slave: pready tied high.

---
 rtl/apb_uart_pkg.sv | 37 +++
 rtl/apb_uart_fifo.sv | 55 +++++
 rtl/apb_uart.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_apb_uart.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART: register map, bit positions, reset
// values and the serial FSM state type used by both TX and RX engines.
package apb_uart_pkg;

    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_UNMAPPED = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;
    localparam int ST_TX_BUSY   = 5;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_RX_IRQ_EN = 2;
    localparam int CTRL_TX_IRQ_EN = 3;
    localparam int CTRL_DIV_LSB   = 16;

    localparam logic [31:0] CTRL_RESET = 32'h0010_0000;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

    // Divisors below 2 would leave no room for a mid-bit sample point.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/apb_uart_fifo.sv
// Synchronous first-word-fall-through FIFO with count-based full/empty;
// pushes into a full FIFO and pops from an empty FIFO are ignored.
module apb_uart_fifo
    import apb_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apb_uart.sv
// APB slave UART: 8N1 transmitter fed by a small FIFO, receiver into a single
// holding register, programmable baud divisor, sticky errors and level irq.
module apb_uart
    import apb_uart_pkg::*;
#(
    parameter int TX_DEPTH  = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);

    logic                 acc;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [1:0]           reg_sel;
    logic                 rd_data;
    logic                 st_wr;

    logic                 tx_en;
    logic                 rx_en;
    logic                 rx_irq_en;
    logic                 tx_irq_en;
    logic [DIV_WIDTH-1:0] div;
    logic [15:0]          period;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    ser_state_t           tx_state;
    ser_state_t           tx_state_nxt;
    logic [15:0]          tx_cnt;
    logic [15:0]          tx_cnt_nxt;
    logic [2:0]           tx_bit;
    logic [2:0]           tx_bit_nxt;
    logic [7:0]           tx_sh;
    logic [7:0]           tx_sh_nxt;
    logic                 txd_nxt;
    logic                 tx_busy;

    logic                 rxd_p0;
    logic                 rxd_p1;
    logic                 rxd_p2;
    ser_state_t           rx_state;
    ser_state_t           rx_state_nxt;
    logic [15:0]          rx_cnt;
    logic [15:0]          rx_cnt_nxt;
    logic [2:0]           rx_bit;
    logic [2:0]           rx_bit_nxt;
    logic [7:0]           rx_sh;
    logic [7:0]           rx_sh_nxt;
    logic                 rx_deliver;
    logic                 rx_accept;

    logic [7:0]           rx_hold;
    logic                 rx_valid;
    logic                 overrun;
    logic                 frame_err;
    logic [31:0]          status_word;
    logic [31:0]          ctrl_word;

    logic                 unused_bits;

    assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata[15:8]};

    assign acc       = psel & penable;
    assign wr_acc    = acc & pwrite;
    assign rd_acc    = acc & ~pwrite;
    assign reg_sel   = paddr[3:2];
    assign rd_data   = rd_acc & (reg_sel == REG_DATA);
    assign st_wr     = wr_acc & (reg_sel == REG_STATUS);
    assign fifo_push = wr_acc & (reg_sel == REG_DATA);
    assign pready    = 1'b1;
    assign period    = bit_period(16'(div));
    assign tx_busy   = (tx_state != SER_IDLE);

    assign status_word = {26'b0, tx_busy, frame_err, overrun, rx_valid, fifo_empty, fifo_full};
    assign ctrl_word   = {16'(div), 12'b0, tx_irq_en, rx_irq_en, rx_en, tx_en};

    apb_uart_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pwdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (acc) begin
            case (reg_sel)
                REG_DATA: begin
                    if (pwrite)        pslverr = fifo_full;
                    else if (rx_valid) prdata  = {24'b0, rx_hold};
                    else               pslverr = 1'b1;
                end
                REG_STATUS: if (!pwrite) prdata = status_word;
                REG_CTRL:   if (!pwrite) prdata = ctrl_word;
                default:    pslverr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en     <= CTRL_RESET[CTRL_TX_EN];
            rx_en     <= CTRL_RESET[CTRL_RX_EN];
            rx_irq_en <= CTRL_RESET[CTRL_RX_IRQ_EN];
            tx_irq_en <= CTRL_RESET[CTRL_TX_IRQ_EN];
            div       <= CTRL_RESET[CTRL_DIV_LSB +: DIV_WIDTH];
        end else if (wr_acc && reg_sel == REG_CTRL) begin
            tx_en     <= pwdata[CTRL_TX_EN];
            rx_en     <= pwdata[CTRL_RX_EN];
            rx_irq_en <= pwdata[CTRL_RX_IRQ_EN];
            tx_irq_en <= pwdata[CTRL_TX_IRQ_EN];
            div       <= pwdata[CTRL_DIV_LSB +: DIV_WIDTH];
        end
    end

    // TX engine: each bit state reloads the counter from the current divisor.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_sh_nxt    = tx_sh;
        txd_nxt      = txd;
        fifo_pop     = 1'b0;
        case (tx_state)
            SER_IDLE: begin
                txd_nxt = 1'b1;
                if (tx_en && !fifo_empty) begin
                    fifo_pop     = 1'b1;
                    tx_sh_nxt    = fifo_dout;
                    tx_state_nxt = SER_START;
                    tx_cnt_nxt   = period - 16'd1;
                    txd_nxt      = 1'b0;
                end
            end
            SER_START: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = SER_DATA;
                    tx_bit_nxt   = 3'd0;
                    tx_cnt_nxt   = period - 16'd1;
                    txd_nxt      = tx_sh[0];
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
            SER_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = period - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = SER_STOP;
                        txd_nxt      = 1'b1;
                    end else begin
                        tx_sh_nxt  = tx_sh >> 1;
                        txd_nxt    = tx_sh[1];
                        tx_bit_nxt = tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
            SER_STOP: begin
                if (tx_cnt == '0) begin
                    // Chain straight into the next start bit so frames are back-to-back.
                    if (tx_en && !fifo_empty) begin
                        fifo_pop     = 1'b1;
                        tx_sh_nxt    = fifo_dout;
                        tx_state_nxt = SER_START;
                        tx_cnt_nxt   = period - 16'd1;
                        txd_nxt      = 1'b0;
                    end else begin
                        tx_state_nxt = SER_IDLE;
                        txd_nxt      = 1'b1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
            default: tx_state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= SER_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            txd      <= txd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh <= tx_sh_nxt;
    end

    // rxd_p0/p1 synchronize the pin; rxd_p2 only serves falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_sh_nxt    = rx_sh;
        rx_deliver   = 1'b0;
        case (rx_state)
            SER_IDLE: begin
                if (rx_en && rxd_p2 && !rxd_p1) begin
                    rx_state_nxt = SER_START;
                    rx_cnt_nxt   = (period >> 1) - 16'd1;
                end
            end
            SER_START: begin
                if (rx_cnt == '0) begin
                    if (!rxd_p1) begin
                        rx_state_nxt = SER_DATA;
                        rx_bit_nxt   = 3'd0;
                        rx_cnt_nxt   = period - 16'd1;
                    end else begin
                        rx_state_nxt = SER_IDLE;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
            SER_DATA: begin
                if (rx_cnt == '0) begin
                    rx_sh_nxt  = {rxd_p1, rx_sh[7:1]};
                    rx_cnt_nxt = period - 16'd1;
                    if (rx_bit == 3'd7) rx_state_nxt = SER_STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
            SER_STOP: begin
                if (rx_cnt == '0) begin
                    rx_deliver   = 1'b1;
                    rx_state_nxt = SER_IDLE;
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
            default: rx_state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= SER_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh <= rx_sh_nxt;
    end

    // A read in the same cycle frees the holding register for the new byte.
    assign rx_accept = ~rx_valid | rd_data;

    always_ff @(posedge clk) begin
        if (rx_deliver && rx_accept) rx_hold <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (st_wr && pwdata[ST_OVERRUN])   overrun   <= 1'b0;
            if (st_wr && pwdata[ST_FRAME_ERR]) frame_err <= 1'b0;
            if (rx_deliver && !rxd_p1)         frame_err <= 1'b1;
            if (rx_deliver) begin
                if (rx_accept) rx_valid <= 1'b1;
                else           overrun  <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= (rx_irq_en & rx_valid) | (tx_irq_en & fifo_empty & ~tx_busy);
    end

endmodule

// File: tb/tb_apb_uart.sv
// Scoreboard bench for apb_uart: APB responses and TX frames are queued as
// expectations by the stimulus and checked by independent monitors.
module tb_apb_uart;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        txd;
    logic        rxd;
    logic        irq;

    apb_uart #(
        .TX_DEPTH  (4),
        .DIV_WIDTH (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .psel    (psel),
        .penable (penable),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .txd     (txd),
        .rxd     (rxd),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        logic        chk;
    } apb_exp_t;

    apb_exp_t   apb_q[$];
    logic [7:0] tx_q[$];
    int         tests = 0;
    int         fails = 0;
    int         tx_div = 16;

    apb_exp_t   mon_e;
    logic [9:0] mon_frame;
    logic [7:0] mon_byte;
    int         mon_div;
    bit         mon_bad;
    bit         mon_abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb(input string name, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input logic chk);
        apb_exp_t e;
        e.name = name;
        e.data = exp_data;
        e.err  = exp_err;
        e.chk  = chk;
        apb_q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_err);
        apb(name, 1'b1, addr, data, 32'h0, exp_err, 1'b0);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                      input logic exp_err);
        apb(name, 1'b0, addr, 32'h0, exp_data, exp_err, 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int d);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (d) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    // APB monitor: every access cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (psel && penable) begin
            if (apb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL apb unexpected access: addr 0x%08h with nothing queued", paddr);
            end else begin
                mon_e = apb_q.pop_front();
                check({mon_e.name, " pslverr"}, {31'b0, pslverr}, {31'b0, mon_e.err});
                if (mon_e.chk) check({mon_e.name, " prdata"}, prdata, mon_e.data);
            end
        end
    end

    // TX monitor: a low txd starts a frame that is checked clock by clock.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                mon_div = tx_div;
                if (tx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx unexpected frame: txd went low with no byte queued");
                    repeat (10 * mon_div) @(negedge clk);
                end else begin
                    mon_byte  = tx_q.pop_front();
                    mon_frame = {1'b1, mon_byte, 1'b0};
                    mon_bad   = 1'b0;
                    mon_abort = 1'b0;
                    for (int i = 0; i < 10 * mon_div; i++) begin
                        if (i > 0) @(negedge clk);
                        if (reset) begin
                            mon_abort = 1'b1;
                            break;
                        end
                        if (!mon_bad && txd !== mon_frame[i / mon_div]) begin
                            mon_bad = 1'b1;
                            $display("FAIL tx frame 0x%02h: txd=%b at clock %0d, expected %b",
                                     mon_byte, txd, i, mon_frame[i / mon_div]);
                        end
                    end
                    if (!mon_abort) begin
                        tests++;
                        if (mon_bad) fails++;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; rxd = 1'b1;
        cycles(4);
        reset = 1'b0;

        check("reset txd", {31'b0, txd}, 32'd1);
        check("reset irq", {31'b0, irq}, 32'd0);
        check("pready", {31'b0, pready}, 32'd1);
        rd("ctrl reset", 32'h8, 32'h0010_0000, 1'b0);
        rd("status reset", 32'h4, 32'h0000_0002, 1'b0);

        // Single frame at div 4.
        tx_div = 4;
        wr("ctrl div4 tx_en", 32'h8, 32'h0004_0001, 1'b0);
        tx_q.push_back(8'hA5);
        wr("data A5", 32'h0, 32'h0000_00A5, 1'b0);
        cycles(8);
        rd("status tx busy", 32'h4, 32'h0000_0022, 1'b0);
        cycles(40);
        rd("status tx done", 32'h4, 32'h0000_0002, 1'b0);

        // Fill the FIFO with TX disabled, overflow it, then drain.
        wr("ctrl tx off", 32'h8, 32'h0004_0000, 1'b0);
        tx_q.push_back(8'h11); wr("data 11", 32'h0, 32'h11, 1'b0);
        tx_q.push_back(8'h22); wr("data 22", 32'h0, 32'h22, 1'b0);
        tx_q.push_back(8'h33); wr("data 33", 32'h0, 32'h33, 1'b0);
        tx_q.push_back(8'h44); wr("data 44", 32'h0, 32'h44, 1'b0);
        wr("data 55 fifo full", 32'h0, 32'h55, 1'b1);
        rd("status fifo full", 32'h4, 32'h0000_0001, 1'b0);
        wr("ctrl tx on", 32'h8, 32'h0004_0001, 1'b0);
        cycles(170);
        rd("status fifo drained", 32'h4, 32'h0000_0002, 1'b0);
        check("tx frames outstanding", tx_q.size(), 32'd0);

        // Receive at div 8 with rx interrupt.
        wr("ctrl rx div8", 32'h8, 32'h0008_0006, 1'b0);
        send_rx(8'h3C, 1'b1, 8);
        cycles(4);
        rd("status rx valid", 32'h4, 32'h0000_0006, 1'b0);
        check("irq rx valid", {31'b0, irq}, 32'd1);
        rd("data 3C", 32'h0, 32'h0000_003C, 1'b0);
        cycles(1);
        check("irq after read", {31'b0, irq}, 32'd0);
        rd("data empty read", 32'h0, 32'h0, 1'b1);

        // Overrun, W1C clear, framing error.
        send_rx(8'h5A, 1'b1, 8);
        send_rx(8'hC3, 1'b1, 8);
        cycles(4);
        rd("status overrun", 32'h4, 32'h0000_000E, 1'b0);
        rd("data retained 5A", 32'h0, 32'h0000_005A, 1'b0);
        wr("status clear overrun", 32'h4, 32'h0000_0008, 1'b0);
        rd("status overrun cleared", 32'h4, 32'h0000_0002, 1'b0);
        send_rx(8'h81, 1'b0, 8);
        cycles(16);
        rd("status frame err", 32'h4, 32'h0000_0016, 1'b0);
        rd("data 81", 32'h0, 32'h0000_0081, 1'b0);
        wr("status clear frame err", 32'h4, 32'h0000_0010, 1'b0);
        rd("status frame err cleared", 32'h4, 32'h0000_0002, 1'b0);

        // Unmapped offset.
        rd("unmapped read", 32'hC, 32'h0, 1'b1);
        wr("unmapped write", 32'hC, 32'hFFFF_FFFF, 1'b1);
        rd("ctrl after unmapped write", 32'h8, 32'h0008_0006, 1'b0);

        // Reset in the middle of a frame with a byte still queued.
        tx_div = 4;
        wr("ctrl div4 tx_en again", 32'h8, 32'h0004_0001, 1'b0);
        tx_q.push_back(8'h96);
        wr("data 96", 32'h0, 32'h96, 1'b0);
        tx_q.push_back(8'h69);
        wr("data 69", 32'h0, 32'h69, 1'b0);
        cycles(10);
        reset = 1'b1;
        tx_q.delete();
        cycles(1);
        check("txd after mid-frame reset", {31'b0, txd}, 32'd1);
        cycles(1);
        reset = 1'b0;
        rd("status after reset", 32'h4, 32'h0000_0002, 1'b0);
        rd("ctrl after reset", 32'h8, 32'h0010_0000, 1'b0);
        cycles(50);
        check("irq after reset", {31'b0, irq}, 32'd0);
        check("apb expectations outstanding", apb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
